// File: rtl/bist_fail_logger.sv
// bist_fail_logger: captures read-compare mismatches from the bist engine
// into a show-ahead FIFO, with fail counter, sticky flags and first address.
module bist_fail_logger #(
  parameter int size   = 6,
  parameter int length = 8,
  parameter int DEPTH  = 4,
  parameter int CNTW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              test_done,
  input  logic              cmp_valid,
  input  logic [size-1:0]   cmp_addr,
  input  logic [length-1:0] cmp_expected,
  input  logic [length-1:0] cmp_actual,
  input  logic              rd_en,
  output logic              log_valid,
  output logic [size-1:0]   log_addr,
  output logic [length-1:0] log_expected,
  output logic [length-1:0] log_actual,
  output logic              fail,
  output logic [size-1:0]   first_fail_addr,
  output logic [CNTW-1:0]   fail_count,
  output logic              overflow,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PONE = 1;
  localparam logic [CNTW-1:0] CONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOG  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [AW:0]       wptr, rptr;
  logic [size-1:0]   mem_addr [DEPTH];
  logic [length-1:0] mem_exp  [DEPTH];
  logic [length-1:0] mem_act  [DEPTH];

  logic empty, full, mis, pop, push, ovf_set;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  assign mis = cmp_valid && (state == LOG) && !arm &&
               (cmp_expected != cmp_actual);
  assign pop = rd_en && !empty && !arm;
  // a simultaneous pop frees the slot the push needs
  assign push    = mis && (!full || pop);
  assign ovf_set = mis && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (arm) begin
      state_nx = LOG;
    end else begin
      unique case (state)
        LOG:     if (test_done) state_nx = DONE;
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    busy         = (state == LOG);
    log_valid    = !empty;
    log_addr     = '0;
    log_expected = '0;
    log_actual   = '0;
    if (!empty) begin
      log_addr     = mem_addr[rptr[AW-1:0]];
      log_expected = mem_exp[rptr[AW-1:0]];
      log_actual   = mem_act[rptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_exp[i]  <= '0;
        mem_act[i]  <= '0;
      end
    end else if (push) begin
      mem_addr[wptr[AW-1:0]] <= cmp_addr;
      mem_exp[wptr[AW-1:0]]  <= cmp_expected;
      mem_act[wptr[AW-1:0]]  <= cmp_actual;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr            <= '0;
      rptr            <= '0;
      fail            <= 1'b0;
      first_fail_addr <= '0;
      fail_count      <= '0;
      overflow        <= 1'b0;
    end else if (arm) begin
      wptr            <= '0;
      rptr            <= '0;
      fail            <= 1'b0;
      first_fail_addr <= '0;
      fail_count      <= '0;
      overflow        <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PONE;
      if (pop)  rptr <= rptr + PONE;
      if (mis) begin
        fail <= 1'b1;
        if (!fail) first_fail_addr <= cmp_addr;
        if (fail_count != '1) fail_count <= fail_count + CONE;
      end
      if (ovf_set) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bist_fail_logger.sv
// tb_bist_fail_logger: table-driven check of the fail logger plus
// hand-written sequences for saturation and asynchronous reset.
module tb_bist_fail_logger;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm, test_done, cmp_valid, rd_en;
  logic [5:0] cmp_addr;
  logic [7:0] cmp_expected, cmp_actual;

  logic       log_valid, fail, overflow, busy;
  logic [5:0] log_addr, first_fail_addr;
  logic [7:0] log_expected, log_actual, fail_count;

  logic       s_log_valid, s_fail, s_overflow, s_busy;
  logic [5:0] s_log_addr, s_first_fail_addr;
  logic [7:0] s_log_expected, s_log_actual;
  logic [2:0] s_fail_count;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  bist_fail_logger dut (
    .clk(clk), .rst(rst), .arm(arm),
    .test_done(test_done),
    .cmp_valid(cmp_valid), .cmp_addr(cmp_addr),
    .cmp_expected(cmp_expected),
    .cmp_actual(cmp_actual), .rd_en(rd_en),
    .log_valid(log_valid), .log_addr(log_addr),
    .log_expected(log_expected),
    .log_actual(log_actual), .fail(fail),
    .first_fail_addr(first_fail_addr),
    .fail_count(fail_count),
    .overflow(overflow), .busy(busy)
  );

  bist_fail_logger #(.CNTW(3)) dut3 (
    .clk(clk), .rst(rst), .arm(arm),
    .test_done(test_done),
    .cmp_valid(cmp_valid), .cmp_addr(cmp_addr),
    .cmp_expected(cmp_expected),
    .cmp_actual(cmp_actual), .rd_en(rd_en),
    .log_valid(s_log_valid), .log_addr(s_log_addr),
    .log_expected(s_log_expected),
    .log_actual(s_log_actual), .fail(s_fail),
    .first_fail_addr(s_first_fail_addr),
    .fail_count(s_fail_count),
    .overflow(s_overflow), .busy(s_busy)
  );

  typedef struct {
    logic       lv;
    logic [5:0] la;
    logic [7:0] le;
    logic [7:0] lx;
    logic       f;
    logic [5:0] ffa;
    logic [7:0] cnt;
    logic       ov;
    logic       b;
  } exp_t;

  typedef struct {
    logic       a;
    logic       d;
    logic       v;
    logic [5:0] ad;
    logic [7:0] e;
    logic [7:0] x;
    logic       r;
    exp_t       o;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic a, logic d, logic v, logic [5:0] ad,
    logic [7:0] e, logic [7:0] x, logic r,
    logic lv, logic [5:0] la, logic [7:0] le,
    logic [7:0] lx, logic f, logic [5:0] ffa,
    logic [7:0] cnt, logic ov, logic b);
    vec_t t;
    t.a = a; t.d = d; t.v = v; t.ad = ad;
    t.e = e; t.x = x; t.r = r;
    t.o.lv = lv; t.o.la = la; t.o.le = le;
    t.o.lx = lx; t.o.f = f; t.o.ffa = ffa;
    t.o.cnt = cnt; t.o.ov = ov; t.o.b = b;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] want);
    ntests++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h",
               nm, got, want);
    end
  endtask

  task automatic check_out(string tag, exp_t o);
    chk({tag, ".log_valid"}, 32'(log_valid), 32'(o.lv));
    chk({tag, ".log_addr"}, 32'(log_addr), 32'(o.la));
    chk({tag, ".log_exp"}, 32'(log_expected), 32'(o.le));
    chk({tag, ".log_act"}, 32'(log_actual), 32'(o.lx));
    chk({tag, ".fail"}, 32'(fail), 32'(o.f));
    chk({tag, ".first"}, 32'(first_fail_addr), 32'(o.ffa));
    chk({tag, ".count"}, 32'(fail_count), 32'(o.cnt));
    chk({tag, ".ovf"}, 32'(overflow), 32'(o.ov));
    chk({tag, ".busy"}, 32'(busy), 32'(o.b));
  endtask

  task automatic drive(logic a, logic d, logic v,
                       logic [5:0] ad, logic [7:0] e,
                       logic [7:0] x, logic r);
    @(negedge clk);
    arm = a; test_done = d; cmp_valid = v;
    cmp_addr = ad; cmp_expected = e;
    cmp_actual = x; rd_en = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 6'd0, 8'd0, 8'd0, 0);
  endtask

  task automatic check_reset(string tag);
    exp_t z;
    z = '{0, 6'd0, 8'd0, 8'd0, 0, 6'd0, 8'd0, 0, 0};
    check_out(tag, z);
    chk({tag, ".s_count"}, 32'(s_fail_count), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    arm = 0; test_done = 0; cmp_valid = 0; rd_en = 0;
    cmp_addr = '0; cmp_expected = '0; cmp_actual = '0;

    #1;
    check_reset("por");
    @(negedge clk);
    rst = 1'b1;

    // 64 matching compares leave no trace
    drive(1, 0, 0, 6'd0, 8'd0, 8'd0, 0);
    for (int i = 0; i < 64; i++)
      drive(0, 0, 1, 6'(i), 8'(i * 3), 8'(i * 3), 0);
    drive(0, 1, 0, 6'd0, 8'd0, 8'd0, 0);
    chk("match.fail", 32'(fail), 32'd0);
    chk("match.count", 32'(fail_count), 32'd0);
    chk("match.lv", 32'(log_valid), 32'd0);
    chk("match.busy", 32'(busy), 32'd0);

    // a d v ad e x r | lv la le lx f ffa cnt ov b
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1));
    tbl.push_back(mk(0,0,1,3,8'h55,8'hFF,0,
                     1,3,8'h55,8'hFF,1,3,1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0,0,0,0,1,3,1,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1));
    tbl.push_back(mk(0,0,1,1,1,8'hFE,0,
                     1,1,1,8'hFE,1,1,1,0,1));
    tbl.push_back(mk(0,0,1,2,2,8'hFD,0,
                     1,1,1,8'hFE,1,1,2,0,1));
    tbl.push_back(mk(0,0,1,3,3,8'hFC,0,
                     1,1,1,8'hFE,1,1,3,0,1));
    tbl.push_back(mk(0,0,1,4,4,8'hFB,0,
                     1,1,1,8'hFE,1,1,4,0,1));
    tbl.push_back(mk(0,0,1,5,5,8'hFA,0,
                     1,1,1,8'hFE,1,1,5,1,1));
    tbl.push_back(mk(0,0,1,6,6,8'hF9,0,
                     1,1,1,8'hFE,1,1,6,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,1,
                     1,2,2,8'hFD,1,1,6,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,1,
                     1,3,3,8'hFC,1,1,6,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,1,
                     1,4,4,8'hFB,1,1,6,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0,0,0,0,1,1,6,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0,0,0,0,1,1,6,1,1));
    tbl.push_back(mk(0,1,0,0,0,0,0, 0,0,0,0,1,1,6,1,0));
    tbl.push_back(mk(0,0,1,7,7,8'hF8,0,
                     0,0,0,0,1,1,6,1,0));
    tbl.push_back(mk(0,1,0,0,0,0,0, 0,0,0,0,1,1,6,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1));
    tbl.push_back(mk(0,0,1,1,1,8'hFE,0,
                     1,1,1,8'hFE,1,1,1,0,1));
    tbl.push_back(mk(0,0,1,2,2,8'hFD,0,
                     1,1,1,8'hFE,1,1,2,0,1));
    tbl.push_back(mk(0,0,1,3,3,8'hFC,0,
                     1,1,1,8'hFE,1,1,3,0,1));
    tbl.push_back(mk(0,0,1,4,4,8'hFB,0,
                     1,1,1,8'hFE,1,1,4,0,1));
    tbl.push_back(mk(0,0,1,9,9,8'hF6,1,
                     1,2,2,8'hFD,1,1,5,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,1,
                     1,3,3,8'hFC,1,1,5,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,1,
                     1,4,4,8'hFB,1,1,5,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,1,
                     1,9,9,8'hF6,1,1,5,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0,0,0,0,1,1,5,0,1));
    tbl.push_back(mk(1,0,1,5,5,8'hFA,1,
                     0,0,0,0,0,0,0,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, 0,0,0,0,0,0,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].a, tbl[i].d, tbl[i].v, tbl[i].ad,
            tbl[i].e, tbl[i].x, tbl[i].r);
      check_out($sformatf("row%0d", i), tbl[i].o);
    end

    // counter saturation on the narrow instance
    drive(1, 0, 0, 6'd0, 8'd0, 8'd0, 0);
    for (int i = 0; i < 10; i++)
      drive(0, 0, 1, 6'(10 + i), 8'h00, 8'h81, 0);
    idle();
    chk("sat.count3", 32'(s_fail_count), 32'd7);
    chk("sat.count8", 32'(fail_count), 32'd10);
    chk("sat.ovf3", 32'(s_overflow), 32'd1);
    chk("sat.first3", 32'(s_first_fail_addr), 32'd10);
    drive(1, 0, 0, 6'd0, 8'd0, 8'd0, 0);
    chk("rearm.count3", 32'(s_fail_count), 32'd0);
    chk("rearm.fail3", 32'(s_fail), 32'd0);
    chk("rearm.ovf3", 32'(s_overflow), 32'd0);
    chk("rearm.lv3", 32'(s_log_valid), 32'd0);
    chk("rearm.busy3", 32'(s_busy), 32'd1);

    // asynchronous reset in the middle of LOG
    drive(0, 0, 1, 6'd12, 8'hAA, 8'h00, 0);
    drive(0, 0, 1, 6'd13, 8'hAA, 8'h01, 0);
    chk("pre_rst.lv", 32'(log_valid), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_reset("async_rst");
    @(negedge clk);
    rst = 1'b1;

    // mismatch while IDLE is ignored
    drive(0, 0, 1, 6'd20, 8'h0F, 8'hF0, 0);
    idle();
    check_reset("idle_cmp");

    $display("[TB] %0d tests run, %0d failed",
             ntests, nfail);
    $finish;
  end

endmodule
